// File: rtl/mm_pkg.sv
// -----------------------------------------------------------------------------
// mm_pkg
// Shared definitions for the matrix-multiply engine. The address generator,
// the input/weight buffers and the output writer all use this package.
//   LANES / LANE_W : lane count and lane width of one datapath beat
//   WORD_W         : width of one packed buffer word
//   mm_state_e     : output-writer state encoding
//   mm_word_t      : packed 512-bit buffer word
// -----------------------------------------------------------------------------
package mm_pkg;

   localparam int LANES  = 16;
   localparam int LANE_W = 32;
   localparam int WORD_W = LANES * LANE_W;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_ACC   = 2'b01,
      ST_FLUSH = 2'b10
   } mm_state_e;

   typedef logic [WORD_W-1:0] mm_word_t;

endpackage : mm_pkg

// File: rtl/mm_lane_adder.sv
// -----------------------------------------------------------------------------
// mm_lane_adder
// LANES-wide lane-wise adder. Each LANE_W-bit lane wraps modulo 2^LANE_W and
// no carry crosses a lane boundary. Purely combinational.
//   a_i   : first operand word, lane k = bits [LANE_W*k +: LANE_W]
//   b_i   : second operand word, same lane layout
//   sum_o : lane-wise wrapping sum
// -----------------------------------------------------------------------------
module mm_lane_adder #(
   parameter int LANES  = mm_pkg::LANES,
   parameter int LANE_W = mm_pkg::LANE_W
) (
   input  logic [LANES*LANE_W-1:0] a_i,
   input  logic [LANES*LANE_W-1:0] b_i,
   output logic [LANES*LANE_W-1:0] sum_o
);

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      // Each slice is added in isolation, so the carry out of a lane is dropped.
      assign sum_o[g*LANE_W +: LANE_W] = a_i[g*LANE_W +: LANE_W] + b_i[g*LANE_W +: LANE_W];
   end

endmodule : mm_lane_adder

// File: rtl/mm_output_writer.sv
// -----------------------------------------------------------------------------
// mm_output_writer
// Output-side receiver of the matrix-multiply engine. Accumulates Ci partial-
// sum beats lane-wise into one output word, writes each completed word to the
// output feature buffer and signals completion after N*Co words.
//   clk, rstn                : clock, asynchronous active-low reset
//   start_valid              : one-cycle job start, latches configuration
//   input_addr_per_feature   : Ci, beats per output word (0 treated as 1)
//   output_addr_per_feature  : Co
//   number_of_node           : N
//   in_valid/in_ready        : partial-sum beat handshake
//   in_addr, in_data         : beat target address and lane data
//   buf_wr_en/addr/data      : registered output-buffer write port
//   busy                     : job in progress
//   done                     : one-cycle completion pulse
//   addr_err                 : sticky, beats of one group disagreed on address
// -----------------------------------------------------------------------------
module mm_output_writer #(
   parameter int LANES  = mm_pkg::LANES,
   parameter int LANE_W = mm_pkg::LANE_W,
   parameter int ADDR_W = 11
) (
   input  logic                      clk,
   input  logic                      rstn,
   input  logic                      start_valid,
   input  logic [7:0]                input_addr_per_feature,
   input  logic [7:0]                output_addr_per_feature,
   input  logic [15:0]               number_of_node,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [ADDR_W-1:0]         in_addr,
   input  logic [LANES*LANE_W-1:0]   in_data,
   output logic                      buf_wr_en,
   output logic [ADDR_W-1:0]         buf_wr_addr,
   output logic [LANES*LANE_W-1:0]   buf_wr_data,
   output logic                      busy,
   output logic                      done,
   output logic                      addr_err
);

   import mm_pkg::*;

   localparam int DW = LANES * LANE_W;

   mm_state_e            state_q, state_d;
   logic [7:0]           ci_q, ci_d;
   logic [23:0]          total_q, total_d;
   logic [7:0]           beat_cnt_q, beat_cnt_d;
   logic [23:0]          word_cnt_q, word_cnt_d;
   logic [DW-1:0]        acc_q, acc_d;
   logic [ADDR_W-1:0]    grp_addr_q, grp_addr_d;
   logic                 addr_err_q, addr_err_d;
   logic                 wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
   logic [DW-1:0]        wr_data_q, wr_data_d;
   logic                 done_q, done_d;

   logic [DW-1:0]        sum;
   logic                 beat_fire;
   logic                 first_beat;
   logic                 last_beat;

   mm_lane_adder #(
      .LANES  (LANES),
      .LANE_W (LANE_W)
   ) u_lane_adder (
      .a_i   (acc_q),
      .b_i   (in_data),
      .sum_o (sum)
   );

   assign beat_fire  = in_valid && (state_q == ST_ACC);
   assign first_beat = (beat_cnt_q == 8'd0);
   assign last_beat  = (beat_cnt_q == 8'(ci_q - 8'd1));

   always_comb begin
      state_d    = state_q;
      ci_d       = ci_q;
      total_d    = total_q;
      beat_cnt_d = beat_cnt_q;
      word_cnt_d = word_cnt_q;
      acc_d      = acc_q;
      grp_addr_d = grp_addr_q;
      addr_err_d = addr_err_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      done_d     = 1'b0;

      if (start_valid) begin
         // A start in any state wins: it drops any partial group and any write
         // that would otherwise be registered this cycle.
         ci_d       = (input_addr_per_feature == 8'd0) ? 8'd1 : input_addr_per_feature;
         total_d    = 24'(number_of_node) * 24'(output_addr_per_feature);
         beat_cnt_d = 8'd0;
         word_cnt_d = 24'd0;
         addr_err_d = 1'b0;
         state_d    = (total_d == 24'd0) ? ST_FLUSH : ST_ACC;
      end else begin
         case (state_q)
            ST_IDLE: begin
               state_d = ST_IDLE;
            end
            ST_ACC: begin
               if (beat_fire) begin
                  if (first_beat) begin
                     acc_d      = in_data;
                     grp_addr_d = in_addr;
                  end else begin
                     acc_d = sum;
                     if (in_addr != grp_addr_q) begin
                        addr_err_d = 1'b1;
                     end
                  end
                  if (last_beat) begin
                     // With ci_eff==1 the last beat is also the first one, so the
                     // beat itself is the word and carries its own address.
                     wr_en_d    = 1'b1;
                     wr_data_d  = first_beat ? in_data : sum;
                     wr_addr_d  = first_beat ? in_addr : grp_addr_q;
                     beat_cnt_d = 8'd0;
                     word_cnt_d = word_cnt_q + 24'd1;
                     if (word_cnt_q == 24'(total_q - 24'd1)) begin
                        state_d = ST_FLUSH;
                        done_d  = 1'b1;
                     end
                  end else begin
                     beat_cnt_d = beat_cnt_q + 8'd1;
                  end
               end
            end
            ST_FLUSH: begin
               // Normally done was raised on entry. An empty job enters FLUSH
               // without it, so it is raised here one cycle later.
               if (done_q) begin
                  state_d = ST_IDLE;
               end else begin
                  done_d = 1'b1;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q    <= ST_IDLE;
         ci_q       <= 8'd1;
         total_q    <= 24'd0;
         beat_cnt_q <= 8'd0;
         word_cnt_q <= 24'd0;
         acc_q      <= '0;
         grp_addr_q <= '0;
         addr_err_q <= 1'b0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ci_q       <= ci_d;
         total_q    <= total_d;
         beat_cnt_q <= beat_cnt_d;
         word_cnt_q <= word_cnt_d;
         acc_q      <= acc_d;
         grp_addr_q <= grp_addr_d;
         addr_err_q <= addr_err_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         done_q     <= done_d;
      end
   end

   assign in_ready    = (state_q == ST_ACC);
   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign addr_err    = addr_err_q;
   assign buf_wr_en   = wr_en_q;
   assign buf_wr_addr = wr_addr_q;
   assign buf_wr_data = wr_data_q;

endmodule : mm_output_writer
